// File: rtl/int_mult_pkg.sv
// Shared types and constants for the int_mult shift-add multiplier.
package int_mult_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_STEP  = 4;
    localparam int ITER      = DEF_WIDTH / DEF_STEP;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        FINISH = 2'd2
    } state_e;

    function automatic int iter_count(input int width, input int step);
        return width / step;
    endfunction

endpackage

// File: rtl/int_mult_step.sv
// Combinational partial-product adder: sum = acc + mcand * digit, wrapped to WIDTH bits.
module mult_step #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [STEP-1:0]  digit_i,
    output logic [WIDTH-1:0] sum_o
);

    // Each set digit bit adds a shifted copy of the multiplicand; carries out of the MSB drop.
    always_comb begin
        sum_o = acc_i;
        for (int b = 0; b < STEP; b++) begin
            if (digit_i[b]) begin
                sum_o = sum_o + (mcand_i << b);
            end
        end
    end

endmodule

// File: rtl/int_mult.sv
// Multi-cycle custom instruction: low WIDTH bits of dataa*datab, STEP multiplier bits per clock.
module int_mult
    import int_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEP  = DEF_STEP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             start,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output state_e           dbg_state_o
);

    localparam int N_ITER = iter_count(WIDTH, STEP);
    localparam int CW     = $clog2(N_ITER + 1);
    localparam logic [CW-1:0] ITER_CNT = CW'(N_ITER);

    if ((WIDTH % STEP) != 0) begin : g_bad_step
        $error("int_mult: STEP must divide WIDTH");
    end

    // Handshake: start is a one-cycle request honoured only in IDLE with clk_en=1;
    // operands are sampled on that edge. done is a one-cycle pulse (stretched only
    // by clk_en=0) and result holds until the next completion or reset.
    state_e            state_q, state_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  step_sum;

    mult_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .digit_i (mplier_q[STEP-1:0]),
        .sum_o   (step_sum)
    );

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = dataa;
                    mplier_d = datab;
                    acc_d    = '0;
                    count_d  = ITER_CNT;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                // Fixed iteration count: no early exit on a zero multiplier.
                if (count_q != '0) begin
                    acc_d    = step_sum;
                    mcand_d  = mcand_q << STEP;
                    mplier_d = mplier_q >> STEP;
                    count_d  = count_q - CW'(1);
                end else begin
                    result_d = acc_q;
                    done_d   = 1'b1;
                    state_d  = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result      = result_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_int_mult.sv
// Self-checking bench for int_mult: vector table, scoreboard queue, multi-cycle corner sequences.
module tb_int_mult;
    import int_mult_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         clk_en;
    logic         start;
    logic [W-1:0] dataa;
    logic [W-1:0] datab;
    logic [W-1:0] result;
    logic         done;
    state_e       dbg_state;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    logic done_prev = 1'b0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;
    vec_t vecs[10];

    int_mult dut (
        .clk         (clk),
        .reset       (reset),
        .clk_en      (clk_en),
        .start       (start),
        .dataa       (dataa),
        .datab       (datab),
        .result      (result),
        .done        (done),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Scoreboard: each rising done pops one expected result.
    always @(negedge clk) begin
        if (reset) begin
            done_prev = 1'b0;
        end else begin
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got result %0h with empty queue", result);
                end else begin
                    check("result", result, exp_q.pop_front());
                end
            end
            done_prev = done;
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dataa = a;
        datab = b;
        start = 1'b1;
        exp_q.push_back(a * b);
        @(negedge clk);
        start = 1'b0;
        dataa = $urandom;
        datab = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        int lat;
        int n;
        logic [W-1:0] last_res;

        vecs[0] = '{32'd1,          32'd2,          32'd2};
        vecs[1] = '{32'hFFFFFFFA,   32'hFFFFFFFA,   32'd36};
        vecs[2] = '{32'd2,          32'd23,         32'd46};
        vecs[3] = '{32'h80000000,   32'd2,          32'd0};
        vecs[4] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1};
        vecs[5] = '{32'd0,          32'h12345678,   32'd0};
        vecs[6] = '{32'h12345678,   32'd1,          32'h12345678};
        vecs[7] = '{32'h00010000,   32'h00010000,   32'd0};
        for (int i = 8; i < 10; i++) begin
            vecs[i].a   = $urandom;
            vecs[i].b   = W'($urandom_range(0, 65535));
            vecs[i].exp = vecs[i].a * vecs[i].b;
        end

        reset  = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        dataa  = '0;
        datab  = '0;
        repeat (2) @(negedge clk);
        check("reset_result", result, '0);
        check("reset_done", W'(done), '0);
        check("reset_state", W'(dbg_state), W'(IDLE));
        reset = 1'b0;

        foreach (vecs[i]) begin
            check("table_model", vecs[i].a * vecs[i].b, vecs[i].exp);
            start_op(vecs[i].a, vecs[i].b);
            wait_done(lat);
            check("latency", W'(lat), 32'd9);
            @(negedge clk);
            check("done_pulse", W'(done), '0);
            check("result_hold", result, vecs[i].exp);
        end

        // Second start during BUSY must be ignored.
        start_op(32'd2, 32'd23);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 2) check("busy_state", W'(dbg_state), W'(BUSY));
            if (lat == 3) begin
                start = 1'b1;
                dataa = 32'd5;
                datab = 32'd7;
            end
            if (lat == 4) start = 1'b0;
            if (done) break;
        end
        check("busy_latency", W'(lat), 32'd9);
        count_dones(12, n);
        check("no_restart", W'(n), '0);
        last_res = 32'd46;

        // clk_en held low for 3 edges mid-op: done delayed by exactly 3.
        start_op(32'h00001111, 32'd3);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 3) clk_en = 1'b0;
            if (lat == 5) check("stall_hold", result, last_res);
            if (lat == 6) clk_en = 1'b1;
            if (done) break;
        end
        check("stall_latency", W'(lat), 32'd12);

        // Frozen in FINISH: done stays high until clk_en returns.
        start_op(32'd3, 32'd5);
        wait_done(lat);
        check("finish_latency", W'(lat), 32'd9);
        clk_en = 1'b0;
        @(negedge clk);
        check("done_frozen_1", W'(done), 32'd1);
        @(negedge clk);
        check("done_frozen_2", W'(done), 32'd1);
        clk_en = 1'b1;
        @(negedge clk);
        check("done_release", W'(done), '0);
        check("result_after_freeze", result, 32'd15);

        // Reset mid-operation aborts without a done.
        start_op(32'h00001234, 32'h10);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_result", result, '0);
        check("midreset_done", W'(done), '0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        count_dones(12, n);
        check("midreset_no_done", W'(n), '0);
        start_op(32'd7, 32'd9);
        wait_done(lat);
        check("post_reset_latency", W'(lat), 32'd9);
        check("post_reset_result", result, 32'd63);

        repeat (2) @(negedge clk);
        check("queue_empty", W'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
